// File: rtl/fp_addsub_sched_pkg.sv
// Shared types and constants for the add/sub scheduler.
package fp_sched_pkg;
  localparam int FP_W    = 32;
  localparam int FLAG_W  = 3;
  localparam int ID_W    = 3;
  localparam int FLG_OVF = 0;
  localparam int FLG_UNF = 1;
  localparam int FLG_EXC = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;
endpackage

// File: rtl/fp_addsub_sched_rr_arbiter.sv
// Round-robin pick: the first set request at or after ptr, wrapping modulo N.
module rr_arbiter
  import fp_sched_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] idx,
  output logic            any
);

  // Walk the ring starting at ptr and keep the first hit.
  always_comb begin
    int j;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = ID_W'(j);
      end
    end
  end

endmodule

// File: rtl/fp_addsub_sched.sv
// Time-shares one combinational FP add/sub unit between NUM_REQ requesters.
// Operands are held on the unit for EXEC_CYCLES cycles (multicycle path),
// then result and flags are returned on a valid/ready channel.
// Optional FP_SCHED_STATS_EN adds saturating response/exception counters.
module fp_addsub_sched
  import fp_sched_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int TAG_W       = 4,
  parameter int EXEC_CYCLES = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [32*NUM_REQ-1:0]    req_n1,
  input  logic [32*NUM_REQ-1:0]    req_n2,
  input  logic [NUM_REQ-1:0]       req_sub,
  input  logic [TAG_W*NUM_REQ-1:0] req_tag,
  output logic [31:0]              core_n1,
  output logic [31:0]              core_n2,
  output logic                     core_sub,
  input  logic [31:0]              core_result,
  input  logic                     core_overflow,
  input  logic                     core_underflow,
  input  logic                     core_exception,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [31:0]              rsp_result,
  output logic [2:0]               rsp_flags,
  output logic [2:0]               rsp_id,
  output logic [TAG_W-1:0]         rsp_tag
`ifdef FP_SCHED_STATS_EN
  ,
  output logic [15:0]              stat_ops,
  output logic [15:0]              stat_exc
`endif
);

  state_t              state;
  logic [ID_W-1:0]     ptr;
  logic [3:0]          cnt;
  logic [NUM_REQ-1:0]  gnt;
  logic [ID_W-1:0]     gidx;
  logic                gany;
  logic [FP_W-1:0]     sel_n1, sel_n2;
  logic                sel_sub;
  logic [TAG_W-1:0]    sel_tag;
  logic [FLAG_W-1:0]   flags_in;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req (req_valid),
    .ptr (ptr),
    .gnt (gnt),
    .idx (gidx),
    .any (gany)
  );

  // Grants are only offered while idle.
  assign req_ready = (state == IDLE) ? gnt : '0;

  // Payload mux driven by the one-hot grant.
  always_comb begin
    sel_n1  = '0;
    sel_n2  = '0;
    sel_sub = 1'b0;
    sel_tag = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_n1  = req_n1[i*FP_W +: FP_W];
        sel_n2  = req_n2[i*FP_W +: FP_W];
        sel_sub = req_sub[i];
        sel_tag = req_tag[i*TAG_W +: TAG_W];
      end
    end
  end

  // Flag bundle as returned to the requester.
  always_comb begin
    flags_in          = '0;
    flags_in[FLG_OVF] = core_overflow;
    flags_in[FLG_UNF] = core_underflow;
    flags_in[FLG_EXC] = core_exception;
  end

  // Scheduler FSM: accept, hold operands for EXEC_CYCLES, then respond.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      cnt        <= '0;
      core_n1    <= '0;
      core_n2    <= '0;
      core_sub   <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_flags  <= '0;
      rsp_id     <= '0;
      rsp_tag    <= '0;
    end else begin
      case (state)
        IDLE: if (gany) begin
          core_n1  <= sel_n1;
          core_n2  <= sel_n2;
          core_sub <= sel_sub;
          rsp_id   <= gidx;
          rsp_tag  <= sel_tag;
          ptr      <= (int'(gidx) == NUM_REQ-1) ? '0 : gidx + 1'b1;
          cnt      <= '0;
          state    <= EXEC;
        end
        EXEC: begin
          cnt <= cnt + 1'b1;
          if (cnt == 4'(EXEC_CYCLES-1)) begin
            rsp_result <= core_result;
            rsp_flags  <= flags_in;
            rsp_valid  <= 1'b1;
            state      <= RESP;
          end
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FP_SCHED_STATS_EN
  logic rsp_hs;
  assign rsp_hs = rsp_valid & rsp_ready;

  // Saturating counters of completed responses and flagged responses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_ops <= '0;
      stat_exc <= '0;
    end else if (rsp_hs) begin
      if (stat_ops != 16'hFFFF) stat_ops <= stat_ops + 1'b1;
      if ((|rsp_flags) && stat_exc != 16'hFFFF) stat_exc <= stat_exc + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fp_addsub_sched.sv
// Directed bench for fp_addsub_sched: a default instance (EXEC_CYCLES=1) and
// a second instance with EXEC_CYCLES=3 share the request inputs. A small
// table-driven stand-in for the add/sub unit feeds each instance.
module tb_fp_addsub_sched;
  localparam int NR = 4;
  localparam int TW = 4;

  logic clk, rst;
  logic [NR-1:0]    req_valid, req_sub;
  logic [32*NR-1:0] req_n1, req_n2;
  logic [TW*NR-1:0] req_tag;

  logic [NR-1:0] req_ready, req_ready3;
  logic [31:0] core_n1, core_n2, core_result, core_n1_3, core_n2_3, core_result3;
  logic core_sub, core_ovf, core_unf, core_exc;
  logic core_sub3, core_ovf3, core_unf3, core_exc3;
  logic rsp_valid, rsp_ready, rsp_valid3, rsp_ready3;
  logic [31:0] rsp_result, rsp_result3;
  logic [2:0] rsp_flags, rsp_flags3, rsp_id, rsp_id3;
  logic [TW-1:0] rsp_tag, rsp_tag3;
`ifdef FP_SCHED_STATS_EN
  logic [15:0] stat_ops, stat_exc, stat_ops3, stat_exc3;
`endif

  int n_asrt = 0;
  int n_fail = 0;

  fp_addsub_sched #(.NUM_REQ(NR), .TAG_W(TW), .EXEC_CYCLES(1)) u0 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_n1(req_n1), .req_n2(req_n2), .req_sub(req_sub), .req_tag(req_tag),
    .core_n1(core_n1), .core_n2(core_n2), .core_sub(core_sub),
    .core_result(core_result), .core_overflow(core_ovf),
    .core_underflow(core_unf), .core_exception(core_exc),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_flags(rsp_flags), .rsp_id(rsp_id), .rsp_tag(rsp_tag)
`ifdef FP_SCHED_STATS_EN
    , .stat_ops(stat_ops), .stat_exc(stat_exc)
`endif
  );

  fp_addsub_sched #(.NUM_REQ(NR), .TAG_W(TW), .EXEC_CYCLES(3)) u3 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready3),
    .req_n1(req_n1), .req_n2(req_n2), .req_sub(req_sub), .req_tag(req_tag),
    .core_n1(core_n1_3), .core_n2(core_n2_3), .core_sub(core_sub3),
    .core_result(core_result3), .core_overflow(core_ovf3),
    .core_underflow(core_unf3), .core_exception(core_exc3),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_result(rsp_result3),
    .rsp_flags(rsp_flags3), .rsp_id(rsp_id3), .rsp_tag(rsp_tag3)
`ifdef FP_SCHED_STATS_EN
    , .stat_ops(stat_ops3), .stat_exc(stat_exc3)
`endif
  );

  // Stand-in add/sub unit: hand-computed IEEE results for the directed
  // vectors, {exc,unf,ovf,result}; anything else returns a pass-through code.
  function automatic logic [34:0] core_model(input logic [31:0] a, b, input logic s);
    if (a == 32'h3F800000 && b == 32'h40000000 && !s) return {3'b000, 32'h40400000}; // 1+2=3
    if (a == 32'h40400000 && b == 32'h3F800000 && s)  return {3'b000, 32'h40000000}; // 3-1=2
    if (a[30:23] == 8'hFF || b[30:23] == 8'hFF)       return {3'b100, 32'h7F800000}; // inf
    if (a == 32'h7F000000 && b == 32'h7F000000 && !s) return {3'b001, 32'h7F800000}; // ovf
    if (a == 32'h00800000 && b == 32'h00800001 && s)  return {3'b010, 32'h80000001}; // unf
    return {3'b000, a ^ b ^ {31'b0, s}};
  endfunction

  always_comb {core_exc, core_unf, core_ovf, core_result} = core_model(core_n1, core_n2, core_sub);
  always_comb {core_exc3, core_unf3, core_ovf3, core_result3} = core_model(core_n1_3, core_n2_3, core_sub3);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, observed timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, b, input logic s, input logic [TW-1:0] t);
    req_n1[i*32 +: 32] = a;
    req_n2[i*32 +: 32] = b;
    req_sub[i]         = s;
    req_tag[i*TW +: TW] = t;
  endtask

  // One full transaction on u0 from requester i alone.
  task automatic do_op(input int i, input logic [31:0] a, b, input logic s,
                       input logic [TW-1:0] t, input logic [31:0] er, input logic [2:0] ef);
    logic [NR-1:0] onehot;
    onehot = '0;
    onehot[i] = 1'b1;
    set_req(i, a, b, s, t);
    req_valid = onehot;
    rsp_ready = 1'b0;
    #1;
    chk("op_grant", req_ready, onehot);
    tick();
    req_valid = '0;
    chk("op_exec_ready", req_ready, 0);
    chk("op_core_n1", core_n1, a);
    chk("op_core_n2", core_n2, b);
    chk("op_core_sub", core_sub, s);
    chk("op_exec_valid", rsp_valid, 0);
    tick();
    chk("op_rsp_valid", rsp_valid, 1);
    chk("op_result", rsp_result, er);
    chk("op_flags", rsp_flags, ef);
    chk("op_id", rsp_id, i);
    chk("op_tag", rsp_tag, t);
    chk("op_resp_ready", req_ready, 0);
    rsp_ready = 1'b1;
    tick();
    chk("op_valid_drop", rsp_valid, 0);
    rsp_ready = 1'b0;
  endtask

  function automatic logic [31:0] n1_of(input int i); return 32'h11111111 * (i + 1); endfunction
  function automatic logic [31:0] n2_of(input int i); return 32'h0F0F0F0F + i; endfunction

  initial begin
    logic [31:0] hold_res;
    rst = 1'b1; req_valid = '0; req_sub = '0; req_n1 = '0; req_n2 = '0; req_tag = '0;
    rsp_ready = 1'b0; rsp_ready3 = 1'b0;
    #2;
    // Reset state
    chk("rst_valid", rsp_valid, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_core_n1", core_n1, 0);
    chk("rst_result", rsp_result, 0);
    chk("rst_id", rsp_id, 0);
`ifdef FP_SCHED_STATS_EN
    chk("rst_stat_ops", stat_ops, 0);
`endif
    tick(); tick();
    rst = 1'b0;

    // Single request from requester 2: 1.0 + 2.0
    do_op(2, 32'h3F800000, 32'h40000000, 1'b0, 4'd5, 32'h40400000, 3'b000);

    // All requesters continuously valid: strict rotation 0,1,2,3,0
    pulse_rst();
    for (int i = 0; i < NR; i++) set_req(i, n1_of(i), n2_of(i), i[0], TW'(8 + i));
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      int e;
      logic [NR-1:0] oh;
      e = k % NR;
      oh = '0;
      oh[e] = 1'b1;
      chk("rr_grant", req_ready, oh);
      tick();
      chk("rr_exec_ready", req_ready, 0);
      chk("rr_id", rsp_id, e);
      chk("rr_tag", rsp_tag, 8 + e);
      tick();
      chk("rr_valid", rsp_valid, 1);
      chk("rr_result", rsp_result, n1_of(e) ^ n2_of(e) ^ {31'b0, e[0]});
      tick();
      chk("rr_valid_drop", rsp_valid, 0);
    end

    // Response stall: fields stable, no grants, pointer frozen
    rsp_ready = 1'b0;
    chk("stall_grant", req_ready, 4'b0010);
    tick();
    tick();
    hold_res = n1_of(1) ^ n2_of(1) ^ 32'd1;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("stall_valid", rsp_valid, 1);
      chk("stall_ready", req_ready, 0);
      chk("stall_id", rsp_id, 1);
      chk("stall_result", rsp_result, hold_res);
    end
    rsp_ready = 1'b1;
    tick();
    chk("stall_release_valid", rsp_valid, 0);
    chk("stall_next_grant", req_ready, 4'b0100);
    // Requests withdrawn before grant: nothing happens
    req_valid = '0;
    tick(); tick();
    chk("withdraw_valid", rsp_valid, 0);
    chk("withdraw_core", core_n1, n1_of(1));
    req_valid = 4'b1011;
    #1;
    chk("withdraw_ptr_kept", req_ready, 4'b1000);
    tick();
    req_valid = '0;
    tick();
    chk("withdraw_id", rsp_id, 3);
    chk("withdraw_result", rsp_result, n1_of(3) ^ n2_of(3) ^ 32'd1);
    tick();
    chk("withdraw_drop", rsp_valid, 0);

    // Flag pass-through (and statistics when enabled)
    pulse_rst();
`ifdef FP_SCHED_STATS_EN
    chk("stat_ops_0", stat_ops, 0);
    chk("stat_exc_0", stat_exc, 0);
`endif
    do_op(0, 32'h7F800000, 32'h3F800000, 1'b0, 4'd3, 32'h7F800000, 3'b100);
`ifdef FP_SCHED_STATS_EN
    chk("stat_ops_1", stat_ops, 1);
    chk("stat_exc_1", stat_exc, 1);
`endif
    do_op(1, 32'h7F000000, 32'h7F000000, 1'b0, 4'd6, 32'h7F800000, 3'b001);
    do_op(2, 32'h00800000, 32'h00800001, 1'b1, 4'd9, 32'h80000001, 3'b010);
    do_op(3, 32'h12345678, 32'h0000FFFF, 1'b0, 4'd15, 32'h1234A987, 3'b000);
`ifdef FP_SCHED_STATS_EN
    chk("stat_ops_4", stat_ops, 4);
    chk("stat_exc_3", stat_exc, 3);
`endif

    // EXEC_CYCLES=3 instance: 3.0 - 1.0, operands held three cycles
    pulse_rst();
    rsp_ready3 = 1'b0;
    set_req(1, 32'h40400000, 32'h3F800000, 1'b1, 4'd7);
    req_valid = 4'b0010;
    #1;
    chk("e3_grant", req_ready3, 4'b0010);
    tick();
    req_valid = '0;
    for (int c = 0; c < 3; c++) begin
      chk("e3_core_n1", core_n1_3, 32'h40400000);
      chk("e3_core_n2", core_n2_3, 32'h3F800000);
      chk("e3_core_sub", core_sub3, 1);
      chk("e3_not_yet", rsp_valid3, 0);
      tick();
    end
    chk("e3_valid", rsp_valid3, 1);
    chk("e3_result", rsp_result3, 32'h40000000);
    chk("e3_flags", rsp_flags3, 0);
    chk("e3_id", rsp_id3, 1);
    chk("e3_tag", rsp_tag3, 7);
    rsp_ready3 = 1'b1;
    tick();
    chk("e3_drop", rsp_valid3, 0);

    // Asynchronous reset during EXEC abandons the operation
    pulse_rst();
    rsp_ready = 1'b0;
    set_req(1, 32'hAAAA5555, 32'h0000FFFF, 1'b0, 4'd2);
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    chk("ar_exec_core", core_n1, 32'hAAAA5555);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_core_n1", core_n1, 0);
    chk("ar_tag", rsp_tag, 0);
    chk("ar_id", rsp_id, 0);
    chk("ar_valid", rsp_valid, 0);
    #1;
    rst = 1'b0;
    rsp_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("ar_no_rsp", rsp_valid, 0);
    end
    req_valid = 4'b0101;
    #1;
    chk("ar_ptr_zero", req_ready, 4'b0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule

// File: doc/fp_addsub_sched.md
Name: fp_addsub_sched

Overview:
- Time-shares one combinational 32-bit IEEE-754 add/sub unit between NUM_REQ requesters.
- Round-robin arbitration picks one requester. Its operands are registered and held stable on the unit for EXEC_CYCLES cycles, as a multicycle path.
- The result and the three flags are captured and returned on a valid/ready response channel, tagged with requester id and user tag.
- Sits between the pipeline front-ends and the shared add/sub datapath.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TAG_W, 4, width of the per-request user tag.
- EXEC_CYCLES, 1, cycles the operands are held on the unit before the result is captured (1..15).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester grant/accept, one-hot or zero.
- req_n1  in  32*NUM_REQ  operand A, packed; slice i = [32*i+31:32*i].
- req_n2  in  32*NUM_REQ  operand B, packed the same way.
- req_sub  in  NUM_REQ  1 = A-B, 0 = A+B.
- req_tag  in  TAG_W*NUM_REQ  user tag, packed.
- core_n1  out  32  operand A to the add/sub unit (registered).
- core_n2  out  32  operand B to the add/sub unit (registered).
- core_sub  out  1  operation select to the unit (registered).
- core_result  in  32  result from the unit.
- core_overflow  in  1  overflow flag from the unit.
- core_underflow  in  1  underflow flag from the unit.
- core_exception  in  1  exception flag from the unit.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_result  out  32  captured result.
- rsp_flags  out  3  {exception, underflow, overflow}, captured.
- rsp_id  out  3  index of the granted requester.
- rsp_tag  out  TAG_W  tag of the granted request.

Behaviour:
- Reset: all outputs and registers are 0, state is IDLE, round-robin pointer ptr=0, exec counter is 0. Reset is asynchronous, so a reset asserted mid-operation abandons that operation and no response is produced.
- States: IDLE, EXEC, RESP.
- IDLE:
  - req_ready[i] is combinational: high only for the first requester with req_valid set, searching i = ptr, ptr+1, ... modulo NUM_REQ.
  - On req_valid[g] & req_ready[g]: latch n1, n2, sub, tag and id=g into the core_* and rsp_id/rsp_tag registers; set ptr=(g+1) mod NUM_REQ; clear the counter; go to EXEC.
  - With no valid request, stay in IDLE and leave ptr unchanged.
- EXEC:
  - All req_ready are 0 and core_* are held constant.
  - The counter increments each cycle.
  - When counter==EXEC_CYCLES-1: capture core_result into rsp_result and the flags into rsp_flags, then go to RESP.
- RESP:
  - rsp_valid=1 and all response fields are stable.
  - On rsp_ready go to IDLE; rsp_valid drops the next cycle.
  - A stall (rsp_ready=0) may last indefinitely. While stalled, no grants are issued and ptr is frozen.
- Latency: accept at edge t, rsp_valid high from cycle t+EXEC_CYCLES+1. Minimum issue interval is EXEC_CYCLES+2 cycles.
- Requesters must hold their payload stable while req_valid=1 and not yet accepted. The scheduler samples the payload only at the accept edge.
- A requester dropping req_valid before it is granted is legal; no state changes as a result.
- With all NUM_REQ requesters continuously valid, grants rotate strictly 0,1,..,NUM_REQ-1,0.
- No arithmetic is done in this block; results and flags pass through unmodified.

Optional Feature:
- Macro FP_SCHED_STATS_EN.
- When defined, adds two outputs:
  - stat_ops (16 bit): count of completed responses, counted on the rsp handshake.
  - stat_exc (16 bit): count of completed responses whose flags are non-zero.
- Both counters saturate at 16'hFFFF and reset to 0.
- When undefined, these ports and registers do not exist and all other behaviour is identical.

Decomposition:
- Package fp_sched_pkg:
  - state enum {IDLE, EXEC, RESP};
  - FP_W=32;
  - FLAG_W=3;
  - flag bit index constants FLG_OVF=0, FLG_UNF=1, FLG_EXC=2.
- One sub-module, rr_arbiter: given the request vector and ptr, it produces the one-hot grant and the encoded index.

Test Plan:
- Single request from req 2: n1=0x3F800000, n2=0x40000000, sub=0, tag=5, with the real add/sub unit attached → rsp_valid at t+2, rsp_result=0x40400000, rsp_flags=0, rsp_id=2, rsp_tag=5.
- All 4 requesters valid continuously, rsp_ready=1 → grant order 0,1,2,3,0. Each req_ready is high for exactly one cycle per grant and never two bits at once.
- rsp_ready held 0 for 10 cycles during RESP → response fields stable, all req_ready=0, ptr frozen. On release, the next grant follows the round-robin order.
- EXEC_CYCLES=3, 3.0-1.0 (0x40400000, 0x3F800000, sub=1) → core_* stable for 3 cycles, rsp_result=0x40000000 at t+4.
- n1=0x7F800000 → rsp_flags[2]=1. With FP_SCHED_STATS_EN defined, stat_exc goes from 0 to 1 and stat_ops from 0 to 1.
- rst pulsed asynchronously during EXEC → outputs are 0 immediately, no response appears, and the next grant goes to req 0.
